uart_rx_fifo: RTL and testbench

Byte buffer directly downstream of the UART receiver. Detects each completed frame from the receiver's `receive_done` level, captures the 8-bit `rx_data` word into a circular FIFO, and presents bytes to the consuming logic (command parser / IoT protocol engine) through a read-enable interface. Absorbs bursts at the serial rate so the consumer can drain at its own pace. Reports fill level and sticky overflow.

---
 rtl/uart_rx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: frame-edge capture,
// circular storage, registered pop port, fill level and sticky overflow.
module uart_rx_fifo #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  receive_done,
   input  logic [7:0]            rx_data,
   input  logic                  rd_en,
   input  logic                  clear_overflow,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic {
      WAIT_LOW = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic                  sync1;
   logic                  sync2;
   logic                  sync3;
   logic [1:0]            settle;
   logic                  armed;
   logic                  wr_req;
   logic                  wr_ok;
   logic                  pop;
   logic                  drop;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [7:0]            mem [DEPTH];

   // Bring receive_done into the clock domain and keep one stage of history
   // for rising-edge detection. settle marks when sync2 holds a sampled pin
   // value rather than its reset value, so a level already high at reset
   // release is never mistaken for a low that arms the capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         settle <= 2'b00;
      end else begin
         sync1  <= receive_done;
         sync2  <= sync1;
         sync3  <= sync2;
         settle <= {settle[0], 1'b1};
      end
   end

   // Control state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= WAIT_LOW;
      end else begin
         state <= state_next;
      end
   end

   // Arm once a genuinely sampled low is seen; only reset disarms.
   always_comb begin
      state_next = state;
      unique case (state)
         WAIT_LOW: if (settle[1] && !sync2) state_next = ACTIVE;
         ACTIVE:   state_next = ACTIVE;
         default:  state_next = WAIT_LOW;
      endcase
   end

   // Control state outputs.
   always_comb begin
      armed = (state == ACTIVE);
   end

   assign wr_req = sync2 & ~sync3 & armed;
   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign pop    = rd_en & ~empty;
   assign wr_ok  = wr_req & (~full | rd_en);
   assign drop   = wr_req & full & ~rd_en;

   // Byte storage; contents survive reset, only pointers are cleared.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   // Pointers, fill level, pop port and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rd_valid <= pop;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
         end
         unique case ({wr_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random
// traffic, compared against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       receive_done;
   logic [7:0] rx_data;
   logic       rd_en;
   logic       clear_overflow;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [7:0] q[$];
   logic [7:0] m_rd;
   logic       m_valid;
   logic       m_ovf;
   int         cd;

   uart_rx_fifo #(
      .DEPTH(DEPTH),
      .ADDR_WIDTH(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .receive_done(receive_done),
      .rx_data(rx_data),
      .rd_en(rd_en),
      .clear_overflow(clear_overflow),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .empty(empty),
      .full(full),
      .count(count),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("count", 32'(count), q.size());
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // Model one clock edge from the inputs currently driven, then compare
   // at the following falling edge. A frame raised before edge N lands at
   // edge N+2, tracked by the cd countdown.
   task automatic tick();
      bit wr;
      bit full_b;
      bit drop;
      wr = (cd == 1);
      if (cd > 0) cd--;
      if (reset) begin
         q.delete();
         m_rd    = 8'h00;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         cd      = 0;
      end else begin
         full_b  = (q.size() == DEPTH);
         m_valid = 1'b0;
         if (rd_en && q.size() > 0) begin
            m_rd    = q.pop_front();
            m_valid = 1'b1;
         end
         drop = 1'b0;
         if (wr) begin
            if (!full_b || rd_en) q.push_back(rx_data);
            else drop = 1'b1;
         end
         if (clear_overflow) m_ovf = 1'b0;
         if (drop) m_ovf = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      check_all();
   endtask

   // mode 0: no pops, 1: pop on the write edge, 2: random pops
   task automatic frame(input logic [7:0] d, input int mode);
      rx_data      = d;
      receive_done = 1'b1;
      cd           = 3;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) receive_done = 1'b0;
         case (mode)
            1:       rd_en = (cd == 1);
            2:       rd_en = 1'($urandom_range(0, 1));
            default: rd_en = 1'b0;
         endcase
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      receive_done   = 1'b0;
      rx_data        = 8'h00;
      rd_en          = 1'b0;
      clear_overflow = 1'b0;
      m_rd           = 8'h00;
      m_valid        = 1'b0;
      m_ovf          = 1'b0;
      cd             = 0;
      @(negedge clock);
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // basic round trip
      frame(8'hA5, 0);
      frame(8'h3C, 0);
      chk("rt_count", 32'(count), 32'd2);
      rd_en = 1'b1;
      tick();
      chk("rt_first", 32'(rd_data), 32'hA5);
      tick();
      chk("rt_second", 32'(rd_data), 32'h3C);
      chk("rt_valid", 32'(rd_valid), 32'd1);
      rd_en = 1'b0;
      tick();
      chk("rt_empty", 32'(empty), 32'd1);

      // fill and overflow
      for (int i = 0; i < DEPTH; i++) frame(8'(i), 0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      frame(8'hFF, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("drain_order", 32'(rd_data), i);
      end
      rd_en = 1'b0;
      tick();
      chk("drain_valid", 32'(rd_valid), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("ovf_clear", 32'(overflow), 32'd0);

      // simultaneous write and pop at full
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 0);
      frame(8'h77, 1);
      chk("sim_count", 32'(count), 32'd16);
      chk("sim_ovf", 32'(overflow), 32'd0);
      rd_en = 1'b1;
      repeat (DEPTH) tick();
      rd_en = 1'b0;
      chk("sim_last", 32'(rd_data), 32'h77);
      tick();

      // pointer wrap with interleaved write/pop
      for (int i = 0; i < 40; i++) begin
         frame(8'(8'h40 + i), 0);
         chk("wrap_cnt1", 32'(count <= 1), 32'd1);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         chk("wrap_data", 32'(rd_data), 32'(8'(8'h40 + i)));
      end

      // random traffic with random pops
      for (int i = 0; i < 40; i++) frame(8'($urandom), 2);
      rd_en = 1'b1;
      repeat (DEPTH + 2) tick();
      rd_en = 1'b0;
      tick();

      // stale frame across reset release
      receive_done = 1'b1;
      rx_data      = 8'hEE;
      do_reset();
      repeat (10) tick();
      chk("stale_count", 32'(count), 32'd0);
      receive_done = 1'b0;
      repeat (3) tick();
      frame(8'h11, 0);
      chk("stale_one", 32'(count), 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("stale_data", 32'(rd_data), 32'h11);
      tick();

      // reset mid-operation
      for (int i = 0; i < 5; i++) frame(8'($urandom), 0);
      chk("mid_count5", 32'(count), 32'd5);
      do_reset();
      chk("mid_count0", 32'(count), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("mid_novalid", 32'(rd_valid), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
